// File: rtl/sudoku_hex2bin_stream.sv
// Streams N*N cell digits in row-major order and assembles them into a one-hot
// board. Illegal digits raise a sticky error and are stored as empty cells.
module sudoku_hex2bin_stream #(
    parameter int unsigned N         = 9,
    parameter int unsigned DW        = 4,
    parameter int unsigned EMPTY_ALL = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_digit,
    output logic                       in_ready,
    input  logic                       abort,
    input  logic                       out_ack,
    output logic [N*N*N-1:0]           board,
    output logic                       board_valid,
    output logic                       err,
    output logic [$clog2(N*N)-1:0]     cell_idx
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned IW    = $clog2(CELLS);
    localparam int unsigned LAST  = CELLS - 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           accept_c;
    logic           last_c;
    logic           illegal_c;
    logic [N-1:0]   mask_c;

    // Digit decode: one-hot for 1..N, empty coding for 0 and illegal values
    always_comb begin
        accept_c  = in_valid && in_ready && !abort;
        last_c    = (cell_idx == IW'(LAST));
        illegal_c = (in_digit > DW'(N));
        mask_c    = '0;
        if (EMPTY_ALL != 0) begin
            mask_c = '1;
        end
        if ((in_digit != '0) && !illegal_c) begin
            mask_c = N'(1) << (in_digit - DW'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides everything, including an out_ack in the same cycle
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_LOAD;
        end else if (state == S_LOAD) begin
            if (accept_c && last_c) begin
                state_next = S_DONE;
            end
        end else if (out_ack) begin
            state_next = S_LOAD;
        end
    end

    always_comb begin
        in_ready    = (state == S_LOAD);
        board_valid = (state == S_DONE);
    end

    // Write pointer and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_idx <= '0;
            err      <= 1'b0;
        end else if (abort) begin
            cell_idx <= '0;
            err      <= 1'b0;
        end else if (accept_c) begin
            cell_idx <= last_c ? '0 : cell_idx + IW'(1);
            if (illegal_c) begin
                err <= 1'b1;
            end
        end else if ((state == S_DONE) && out_ack) begin
            err <= 1'b0;
        end
    end

    // Unwritten cells keep their previous contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board <= '0;
        end else if (accept_c) begin
            for (int i = 0; i < CELLS; i++) begin
                if (cell_idx == IW'(i)) begin
                    board[i*N +: N] <= mask_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_sudoku_hex2bin_stream.sv
// Bench for sudoku_hex2bin_stream: N=9 (both empty codings) against a digit-level
// model, plus a vector table for an N=4 instance.
module tb_sudoku_hex2bin_stream;

    logic clk;
    logic reset;

    logic         v9, ab9, ack9;
    logic [3:0]   d9;
    logic         rdy_a, bv_a, err_a, rdy_b, bv_b, err_b;
    logic [728:0] brd_a, brd_b;
    logic [6:0]   idx_a, idx_b;

    logic         v4, ab4, ack4;
    logic [2:0]   d4;
    logic         rdy4, bv4, err4;
    logic [63:0]  brd4;
    logic [3:0]   idx4;

    int checks = 0;
    int errors = 0;

    sudoku_hex2bin_stream #(.N(9), .DW(4), .EMPTY_ALL(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(v9), .in_digit(d9), .in_ready(rdy_a),
        .abort(ab9), .out_ack(ack9), .board(brd_a), .board_valid(bv_a),
        .err(err_a), .cell_idx(idx_a));

    sudoku_hex2bin_stream #(.N(9), .DW(4), .EMPTY_ALL(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(v9), .in_digit(d9), .in_ready(rdy_b),
        .abort(ab9), .out_ack(ack9), .board(brd_b), .board_valid(bv_b),
        .err(err_b), .cell_idx(idx_b));

    sudoku_hex2bin_stream #(.N(4), .DW(3), .EMPTY_ALL(0)) dut_4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_digit(d4), .in_ready(rdy4),
        .abort(ab4), .out_ack(ack4), .board(brd4), .board_valid(bv4),
        .err(err4), .cell_idx(idx4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: digits per cell, frame position, done flag, sticky error
    logic [8:0] mb0 [81];
    logic [8:0] mb1 [81];
    bit         m_done;
    int         m_idx;
    bit         m_err;

    function automatic logic [8:0] emask(input int d, input bit e);
        if (d >= 1 && d <= 9) return 9'(1 << (d - 1));
        return e ? 9'h1FF : 9'h000;
    endfunction

    function automatic logic [728:0] build(input bit e);
        logic [728:0] r;
        r = '0;
        for (int i = 0; i < 81; i++) r[i*9 +: 9] = e ? mb1[i] : mb0[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 81; i++) begin
            mb0[i] = '0;
            mb1[i] = '0;
        end
        m_done = 0;
        m_idx  = 0;
        m_err  = 0;
    endtask

    task automatic model_step();
        if (ab9) begin
            m_done = 0;
            m_idx  = 0;
            m_err  = 0;
        end else if (!m_done) begin
            if (v9) begin
                mb0[m_idx] = emask(int'(d9), 1'b0);
                mb1[m_idx] = emask(int'(d9), 1'b1);
                if (int'(d9) > 9) m_err = 1;
                if (m_idx == 80) begin
                    m_done = 1;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
        end else if (ack9) begin
            m_done = 0;
            m_err  = 0;
        end
    endtask

    task automatic check9();
        chk("ready_e0", 768'(rdy_a), 768'(!m_done));
        chk("ready_e1", 768'(rdy_b), 768'(!m_done));
        chk("bvalid_e0", 768'(bv_a), 768'(m_done));
        chk("bvalid_e1", 768'(bv_b), 768'(m_done));
        chk("err_e0", 768'(err_a), 768'(m_err));
        chk("err_e1", 768'(err_b), 768'(m_err));
        chk("idx_e0", 768'(idx_a), 768'(m_idx));
        chk("idx_e1", 768'(idx_b), 768'(m_idx));
        if (m_done) begin
            chk("board_e0", 768'(brd_a), 768'(build(1'b0)));
            chk("board_e1", 768'(brd_b), 768'(build(1'b1)));
        end
    endtask

    task automatic drive9(input logic v, input logic [3:0] d, input logic ab, input logic ack);
        v9 = v; d9 = d; ab9 = ab; ack9 = ack;
    endtask

    task automatic cyc9();
        @(posedge clk);
        model_step();
        #1;
        check9();
    endtask

    function automatic logic [3:0] legal9();
        return 4'($urandom_range(1, 9));
    endfunction

    function automatic logic [3:0] any9();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    typedef struct {
        logic        v;
        logic [2:0]  d;
        logic        ab;
        logic        ack;
        logic [3:0]  idx;
        logic        er;
        logic        bv;
        logic        cb;
        logic [63:0] brd;
    } vec4_t;

    vec4_t tab [22];
    localparam logic [63:0] BRD4 = 64'h2184_2184_2108_0421;

    initial begin
        // N=4 vectors: expected state after the edge on which the inputs apply
        tab[0]  = '{1'b1, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 64'h0};
        tab[1]  = '{1'b1, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 64'h0};
        tab[2]  = '{1'b0, 3'd7, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 64'h0};
        tab[3]  = '{1'b1, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 64'h0};
        tab[4]  = '{1'b1, 3'd5, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 64'h0};
        tab[5]  = '{1'b1, 3'd4, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 64'h0};
        tab[6]  = '{1'b1, 3'd0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 64'h0};
        for (int k = 0; k < 9; k++)
            tab[7+k] = '{1'b1, 3'((k % 4) + 1), 1'b0, 1'b0, 4'(7 + k), 1'b1, 1'b0, 1'b0, 64'h0};
        tab[16] = '{1'b1, 3'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, BRD4};
        tab[17] = '{1'b1, 3'd3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, BRD4};
        tab[18] = '{1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 64'h0};
        tab[19] = '{1'b1, 3'd7, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 64'h0};
        tab[20] = '{1'b1, 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 64'h0};
        tab[21] = '{1'b1, 3'd2, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 64'h0};

        reset = 1'b1;
        drive9(0, 4'd0, 0, 0);
        v4 = 0; d4 = '0; ab4 = 0; ack4 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check9();
        chk("rst4_ready", 768'(rdy4), 768'(1));
        chk("rst4_board", 768'(brd4), 768'(0));
        chk("rst4_idx", 768'(idx4), 768'(0));

        for (int r = 0; r < 22; r++) begin
            v4 = tab[r].v; d4 = tab[r].d; ab4 = tab[r].ab; ack4 = tab[r].ack;
            @(posedge clk);
            #1;
            chk($sformatf("n4_idx_r%0d", r), 768'(idx4), 768'(tab[r].idx));
            chk($sformatf("n4_err_r%0d", r), 768'(err4), 768'(tab[r].er));
            chk($sformatf("n4_bv_r%0d", r), 768'(bv4), 768'(tab[r].bv));
            chk($sformatf("n4_ready_r%0d", r), 768'(rdy4), 768'(!tab[r].bv));
            if (tab[r].cb) chk($sformatf("n4_board_r%0d", r), 768'(brd4), 768'(tab[r].brd));
        end
        v4 = 0; ab4 = 0; ack4 = 0;

        // Full legal frame 1..9 repeating, then DONE hold with in_valid toggling
        for (int i = 0; i < 81; i++) begin
            drive9(1, 4'((i % 9) + 1), 0, 0);
            cyc9();
        end
        chk("a_cell0", 768'(brd_a[8:0]), 768'(9'h001));
        chk("a_cell8", 768'(brd_a[80:72]), 768'(9'h100));
        chk("a_bv", 768'(bv_a), 768'(1));
        chk("a_err", 768'(err_a), 768'(0));
        chk("a_ready", 768'(rdy_a), 768'(0));
        for (int i = 0; i < 10; i++) begin
            drive9(1'(i % 2), any9(), 0, 0);
            cyc9();
        end
        drive9(0, 4'd0, 0, 1);
        cyc9();
        chk("b_ready", 768'(rdy_a), 768'(1));
        chk("b_bv", 768'(bv_a), 768'(0));

        // Empty and illegal cells in both codings
        for (int i = 0; i < 81; i++) begin
            drive9(1, (i == 5) ? 4'd0 : (i == 6) ? 4'hC : legal9(), 0, 0);
            cyc9();
            if (i == 5) chk("c_err_before", 768'(err_b), 768'(0));
            if (i == 6) chk("c_err_rise", 768'(err_b), 768'(1));
        end
        chk("c_e1_cell5", 768'(brd_b[53:45]), 768'(9'h1FF));
        chk("c_e1_cell6", 768'(brd_b[62:54]), 768'(9'h1FF));
        chk("c_e0_cell5", 768'(brd_a[53:45]), 768'(9'h000));
        chk("c_e0_cell6", 768'(brd_a[62:54]), 768'(9'h000));
        drive9(0, 4'd0, 0, 0);
        repeat (3) cyc9();
        drive9(0, 4'd0, 0, 1);
        cyc9();
        chk("c_err_clr", 768'(err_b), 768'(0));

        // Abort colliding with an accept, then a clean frame, then abort+ack in DONE
        for (int i = 0; i < 40; i++) begin
            drive9(1, (i == 12) ? 4'hE : legal9(), 0, 0);
            cyc9();
        end
        drive9(1, 4'd3, 1, 0);
        cyc9();
        chk("d_idx", 768'(idx_a), 768'(0));
        chk("d_err", 768'(err_a), 768'(0));
        for (int i = 0; i < 81; i++) begin
            drive9(1, legal9(), 0, 0);
            cyc9();
        end
        chk("d_bv", 768'(bv_a), 768'(1));
        drive9(0, 4'd0, 1, 1);
        cyc9();

        // Asynchronous reset mid-frame
        for (int i = 0; i < 30; i++) begin
            drive9(1, (i == 10) ? 4'hF : legal9(), 0, 0);
            cyc9();
        end
        drive9(0, 4'd0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("e_idx", 768'(idx_a), 768'(0));
        chk("e_err", 768'(err_a), 768'(0));
        chk("e_bv", 768'(bv_a), 768'(0));
        chk("e_ready", 768'(rdy_a), 768'(1));
        chk("e_board_e0", 768'(brd_a), 768'(0));
        chk("e_board_e1", 768'(brd_b), 768'(0));
        model_reset();
        #2 reset = 1'b0;
        for (int i = 0; i < 81; i++) begin
            drive9(1, any9(), 0, 0);
            cyc9();
        end
        drive9(0, 4'd0, 0, 1);
        cyc9();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive9(1'($urandom_range(0, 9) < 7), any9(),
                   1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) == 0));
            cyc9();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sudoku_hex2bin_stream.md
SUDOKU_HEX2BIN_STREAM -- requirements
Module: sudoku_hex2bin_stream

Interface
REQ-001 SHALL have parameter N, default 9, meaning board side; legal values 4, 9, 16; board holds N*N cells.
REQ-002 SHALL have parameter DW, default 4, meaning digit width; requires 2**DW > N (N=16 needs DW=5).
REQ-003 SHALL have parameter EMPTY_ALL, default 0, meaning empty-cell coding: 0 = all-zeros mask, 1 = all-ones candidate mask.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  in_digit carries a cell digit this cycle.
REQ-008 in_digit  input  DW  cell value: 0 = empty, 1..N = digit, >N = illegal.
REQ-009 in_ready  output  1  block accepts a digit this cycle.
REQ-010 abort  input  1  synchronous frame discard.
REQ-011 out_ack  input  1  consumer has taken the board.
REQ-012 board  output  N*N*N  one-hot board; cell i occupies bits [i*N +: N].
REQ-013 board_valid  output  1  board complete and stable.
REQ-014 err  output  1  sticky: an illegal digit was seen in the current frame.
REQ-015 cell_idx  output  ceil(log2(N*N))  index of the next cell to be written.

Function
REQ-016 SHALL implement FSM states LOAD and DONE.
REQ-017 In LOAD, in_ready SHALL be 1; in DONE, in_ready SHALL be 0.
REQ-018 A digit SHALL be accepted on a rising edge when in_valid and in_ready are both 1; in_digit is ignored otherwise.
REQ-019 An accepted digit SHALL be written to cell cell_idx, and cell_idx SHALL then increment by 1.
REQ-020 The first accepted digit of a frame SHALL be cell 0, in row-major order.
REQ-021 Digit d in 1..N SHALL be written as a mask with only bit d-1 set.
REQ-022 Digit 0 SHALL be written as all-zeros when EMPTY_ALL=0, or as all-ones when EMPTY_ALL=1.
REQ-023 Digit >N SHALL be written as the empty-cell coding (REQ-022), and err SHALL be set on the same edge.
REQ-024 Acceptance at cell_idx = N*N-1 SHALL move the FSM to DONE, wrap cell_idx to 0 and set board_valid, all on that edge; latency from last accept to board_valid = 1 cycle.
REQ-025 In DONE, board, err and board_valid SHALL be held until out_ack or abort.
REQ-026 out_ack in DONE SHALL move the FSM to LOAD, clear board_valid and err, and leave cell_idx at 0.
REQ-027 out_ack in LOAD SHALL be ignored.
REQ-028 abort in any state SHALL, on the next edge, force LOAD, cell_idx=0, board_valid=0 and err=0.
REQ-029 abort together with an accept SHALL discard the digit; abort wins.
REQ-030 abort together with out_ack SHALL give the same result as abort alone.
REQ-031 Cells not yet written in a frame SHALL keep their previous contents; board is defined only while board_valid=1.
REQ-032 err SHALL never clear within a frame; it clears only via REQ-026, REQ-028 or reset.

Reset
REQ-033 reset SHALL asynchronously force: LOAD, cell_idx=0, board all-zeros, board_valid=0, err=0.
REQ-034 After reset deassertion, in_ready SHALL be 1.
REQ-035 Reset mid-frame SHALL discard all partial data.

Verification
REQ-036 N=9, EMPTY_ALL=0: stream 81 digits 1..9 repeating, in_valid held high -> board_valid rises 1 cycle after the 81st accept; cell0=9'h001, cell8=9'h100; err=0; in_ready=0 in DONE.
REQ-037 N=9, EMPTY_ALL=1: cell 5 digit 0 and cell 6 digit 4'hC -> cell5=9'h1FF, cell6=9'h1FF; err rises on the cell-6 accept edge and holds until out_ack.
REQ-038 Send 40 digits, assert abort with in_valid=1 on the same cycle -> cell_idx=0 next cycle, err=0, that digit discarded; a new 81-digit frame then completes normally.
REQ-039 In DONE, toggle in_valid and hold out_ack=0 for 10 cycles -> board unchanged, board_valid stays 1; then out_ack=1 for 1 cycle -> LOAD, in_ready=1, board_valid=0.
REQ-040 Assert reset asynchronously mid-frame (cell_idx=30) -> all outputs at reset values without a clock edge; next frame starts at cell 0.
REQ-041 N=4, DW=3: 16-digit frame, digit 5 in cell 3 -> err=1, cell3=4'h0; board_valid after the 16th accept.
